mandelbrot_render: RTL and testbench

//  Frame-level initiator for a single Mandelbrot iteration core (start/re/im -> iter/done).

---
 rtl/mandelbrot_render.sv | 141 ++++++++++++++
 tb/tb_mandelbrot_render.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_render.sv
// Raster-order frame sequencer for one Mandelbrot core: one job per pixel, iter written to the framebuffer.
// Optional `MANDEL_ABORT_EN adds an abort input that drains the in-flight job before returning to idle.
module mandelbrot_render #(
   parameter int FP_WIDTH = 25,
   parameter int ITERW    = 8,
   parameter int H_RES    = 320,
   parameter int V_RES    = 180,
   parameter int ADDRW    = $clog2(H_RES*V_RES)
) (
   input  logic                clk,
   input  logic                rst,
`ifdef MANDEL_ABORT_EN
   input  logic                abort,
`endif
   input  logic                start,
   input  logic [FP_WIDTH-1:0] x_start,
   input  logic [FP_WIDTH-1:0] y_start,
   input  logic [FP_WIDTH-1:0] step,
   output logic                busy,
   output logic                frame_done,
   output logic                core_start,
   output logic [FP_WIDTH-1:0] core_re,
   output logic [FP_WIDTH-1:0] core_im,
   input  logic [ITERW-1:0]    core_iter,
   input  logic                core_done,
   output logic                fb_we,
   output logic [ADDRW-1:0]    fb_addr,
   output logic [ITERW-1:0]    fb_din
);

   localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
`ifdef MANDEL_ABORT_EN
      , DRAIN
`endif
   } state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       col;
   logic [RW-1:0]       row;
   logic [ADDRW-1:0]    pix_addr;
   logic [FP_WIDTH-1:0] x_start_l, step_l;
   logic                accept, pix_done, last_px;

   assign last_px    = (col == CW'(H_RES-1)) && (row == RW'(V_RES-1));
   assign core_start = (state == ISSUE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      pix_done  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
`ifdef MANDEL_ABORT_EN
            if (abort) state_nxt = DRAIN;
`endif
         end
         WAIT: begin
`ifdef MANDEL_ABORT_EN
            // an abort coinciding with the result discards it and skips the drain
            if (abort) state_nxt = core_done ? IDLE : DRAIN;
            else
`endif
            if (core_done) begin
               pix_done  = 1'b1;
               state_nxt = last_px ? IDLE : ISSUE;
            end
         end
`ifdef MANDEL_ABORT_EN
         DRAIN: begin
            if (core_done) state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // fb_addr is a separate output register so the write carries the finished pixel while pix_addr moves on
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_we      <= 1'b0;
         frame_done <= 1'b0;
         fb_addr    <= '0;
         fb_din     <= '0;
         core_re    <= '0;
         core_im    <= '0;
         x_start_l  <= '0;
         step_l     <= '0;
         col        <= '0;
         row        <= '0;
         pix_addr   <= '0;
      end else begin
         fb_we      <= pix_done;
         frame_done <= pix_done && last_px;
         if (pix_done) begin
            fb_din  <= core_iter;
            fb_addr <= pix_addr;
         end
         if (accept) begin
            x_start_l <= x_start;
            step_l    <= step;
            core_re   <= x_start;
            core_im   <= y_start;
            col       <= '0;
            row       <= '0;
            pix_addr  <= '0;
            fb_addr   <= '0;
         end else if (pix_done && !last_px) begin
            pix_addr <= pix_addr + ADDRW'(1);
            if (col != CW'(H_RES-1)) begin
               col     <= col + CW'(1);
               core_re <= core_re + step_l;
            end else begin
               col     <= '0;
               row     <= row + RW'(1);
               core_re <= x_start_l;
               core_im <= core_im - step_l;
            end
         end
      end
   end

endmodule

// File: tb/tb_mandelbrot_render.sv
// Bench for mandelbrot_render on a 4x2 grid with a variable-latency core model and a coordinate/address reference model.
// Abort scenarios build only when MANDEL_ABORT_EN is defined.
module tb_mandelbrot_render;
   localparam int FPW  = 25;
   localparam int IW   = 8;
   localparam int H    = 4;
   localparam int V    = 2;
   localparam int NPIX = H*V;
   localparam int AW   = $clog2(NPIX);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [FPW-1:0] x_start = '0, y_start = '0, step = '0;
   logic           busy, frame_done, core_start, fb_we;
   logic [FPW-1:0] core_re, core_im;
   logic [IW-1:0]  core_iter;
   logic           core_done;
   logic [AW-1:0]  fb_addr;
   logic [IW-1:0]  fb_din;
`ifdef MANDEL_ABORT_EN
   logic           abort = 1'b0;
`endif

   mandelbrot_render #(.FP_WIDTH(FPW), .ITERW(IW), .H_RES(H), .V_RES(V), .ADDRW(AW)) dut (
      .clk(clk), .rst(rst),
`ifdef MANDEL_ABORT_EN
      .abort(abort),
`endif
      .start(start), .x_start(x_start), .y_start(y_start), .step(step),
      .busy(busy), .frame_done(frame_done), .core_start(core_start),
      .core_re(core_re), .core_im(core_im), .core_iter(core_iter), .core_done(core_done),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   // Core model and bus recorder
   int             core_lat = 1, pending = 0, job_cnt = 0;
   int             fd_cnt = 0, fd_with_we = 0, unstable = 0;
   logic [FPW-1:0] job_re, job_im;
   logic [IW-1:0]  job_iter;
   logic [FPW-1:0] q_re[$], q_im[$];
   logic [AW-1:0]  q_addr[$];
   logic [IW-1:0]  q_dat[$];

   initial begin
      core_done = 1'b0;
      core_iter = '0;
      forever begin
         @(posedge clk); #1;
         core_done = 1'b0;
         if (rst) pending = 0;
         if (fb_we) begin q_addr.push_back(fb_addr); q_dat.push_back(fb_din); end
         if (frame_done) begin fd_cnt++; if (fb_we) fd_with_we++; end
         if (pending > 0) begin
            if (core_re !== job_re || core_im !== job_im) unstable++;
            pending--;
            if (pending == 0) begin core_done = 1'b1; core_iter = job_iter; end
         end
         if (core_start) begin
            job_re = core_re; job_im = core_im;
            q_re.push_back(core_re); q_im.push_back(core_im);
            job_iter = IW'(job_cnt + 3);
            job_cnt++;
            pending = core_lat;
         end
      end
   end

   // Pixel (r,c) sits at x + c*step, y - r*step, address r*H+c, modulo 2^FPW
   function automatic logic [FPW-1:0] m_re(input logic [FPW-1:0] x, input logic [FPW-1:0] s, input int c);
      return x + s * FPW'(c);
   endfunction
   function automatic logic [FPW-1:0] m_im(input logic [FPW-1:0] y, input logic [FPW-1:0] s, input int r);
      return y - s * FPW'(r);
   endfunction

   task automatic clear_log();
      q_re.delete(); q_im.delete(); q_addr.delete(); q_dat.delete();
      fd_cnt = 0; fd_with_we = 0; unstable = 0; job_cnt = 0;
   endtask

   task automatic launch(input logic [FPW-1:0] x, input logic [FPW-1:0] y, input logic [FPW-1:0] s);
      @(posedge clk); #2;
      x_start = x; y_start = y; step = s; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_jobs(input int n, input string name);
      int t = 0;
      while (job_cnt < n && t < 5000) begin @(posedge clk); #2; t++; end
      checks++;
      if (job_cnt < n) begin errors++; $display("FAIL %s_jobs: got %0d jobs, wanted %0d", name, job_cnt, n); end
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (busy && t < 5000) begin @(posedge clk); #2; t++; end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_timeout: busy=%b, wanted 0", name, busy); end
   endtask

   // Runs one whole frame and compares every job and write against the model
   task automatic test_frame(input logic [FPW-1:0] x, input logic [FPW-1:0] y, input logic [FPW-1:0] s,
                             input int lat, input bit poke, input string name);
      clear_log();
      core_lat = lat;
      launch(x, y, s);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b, wanted 1", name, busy); end
      if (poke) begin
         repeat (15) @(posedge clk);
         #2; x_start = x ^ 25'h0ABCDE; y_start = y + 25'h12345; step = s + 25'h40000; start = 1'b1;
         repeat (3) @(posedge clk);
         #2; start = 1'b0;
      end
      wait_idle(name);
      @(posedge clk); #2;
      checks++;
      if (q_re.size() != NPIX) begin errors++; $display("FAIL %s_jobs: got %0d, wanted %0d", name, q_re.size(), NPIX); end
      checks++;
      if (q_addr.size() != NPIX) begin errors++; $display("FAIL %s_writes: got %0d, wanted %0d", name, q_addr.size(), NPIX); end
      for (int k = 0; k < NPIX && k < q_re.size(); k++) begin
         checks++;
         if (q_re[k] !== m_re(x, s, k % H) || q_im[k] !== m_im(y, s, k / H)) begin
            errors++;
            $display("FAIL %s_coord[%0d]: got re=%h im=%h, wanted re=%h im=%h", name, k, q_re[k], q_im[k],
                     m_re(x, s, k % H), m_im(y, s, k / H));
         end
      end
      for (int k = 0; k < NPIX && k < q_addr.size(); k++) begin
         checks++;
         if (q_addr[k] !== AW'(k) || q_dat[k] !== IW'(k + 3)) begin
            errors++;
            $display("FAIL %s_write[%0d]: got addr=%0d din=%0d, wanted addr=%0d din=%0d", name, k, q_addr[k], q_dat[k], k, k + 3);
         end
      end
      checks++;
      if (fd_cnt != 1 || fd_with_we != 1) begin
         errors++; $display("FAIL %s_frame_done: got %0d pulses (%0d with fb_we), wanted 1 (1)", name, fd_cnt, fd_with_we);
      end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL %s_stable: got %0d coordinate changes while waiting, wanted 0", name, unstable); end
      x_start = '0; y_start = '0; step = '0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({busy, frame_done, core_start, fb_we} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl: got busy/fd/cs/we=%b, wanted 0000", {busy, frame_done, core_start, fb_we});
      end
      checks++;
      if (core_re !== '0 || core_im !== '0 || fb_addr !== '0 || fb_din !== '0) begin
         errors++; $display("FAIL reset_data: got re=%h im=%h addr=%0d din=%0d, wanted all 0", core_re, core_im, fb_addr, fb_din);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_basic();
      test_frame(-25'sd4194304, 25'd1048576, 25'd1048576, 1, 1'b0, "basic");
   endtask

   task automatic test_latency();
      test_frame(25'h1F00000, 25'h0080000, 25'h0020000, 300, 1'b0, "lat300");
      for (int i = 0; i < 3; i++)
         test_frame(FPW'($urandom), FPW'($urandom), FPW'($urandom), int'($urandom_range(1, 12)), 1'b0, "latrand");
   endtask

   task automatic test_start_ignored();
      test_frame(-25'sd4194304, 25'd1048576, 25'd1048576, 10, 1'b1, "start_busy");
   endtask

   task automatic test_reset_mid();
      clear_log();
      core_lat = 6;
      launch(25'h0123456, 25'h0654321, 25'h0010000);
      wait_jobs(6, "rst_mid");
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, frame_done, core_start, fb_we} !== 4'b0 || core_re !== '0 || core_im !== '0 || fb_addr !== '0 || fb_din !== '0) begin
         errors++; $display("FAIL rst_mid_outputs: got busy=%b re=%h im=%h addr=%0d din=%0d, wanted all 0", busy, core_re, core_im, fb_addr, fb_din);
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      checks++;
      if (q_addr.size() != 5 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_mid_writes: got %0d writes busy=%b, wanted 5 writes busy=0", q_addr.size(), busy);
      end
      for (int k = 0; k < q_addr.size(); k++) begin
         checks++;
         if (q_addr[k] !== AW'(k)) begin errors++; $display("FAIL rst_mid_addr[%0d]: got %0d, wanted %0d", k, q_addr[k], k); end
      end
      test_frame(25'h0123456, 25'h0654321, 25'h0010000, 2, 1'b0, "rst_restart");
   endtask

   task automatic test_wrap();
      test_frame(25'h07FFFFF, 25'h0, 25'd1048576, 1, 1'b0, "wrap_spec");
      test_frame(25'h0FFFFFF, 25'h1000000, 25'd1048576, 1, 1'b0, "wrap_edge");
      checks++;
      if (q_re.size() < 5 || q_re[1][FPW-1] !== 1'b1 || q_im[4][FPW-1] !== 1'b0) begin
         errors++; $display("FAIL wrap_sign: got %0d jobs, re[1]=%h im[4]=%h, wanted re[1] negative im[4] positive",
                            q_re.size(), q_re.size() > 1 ? q_re[1] : '0, q_im.size() > 4 ? q_im[4] : '0);
      end
   endtask

`ifdef MANDEL_ABORT_EN
   task automatic test_abort();
      int t;
      clear_log();
      core_lat = 30;
      launch(25'h0100000, 25'h0200000, 25'h0008000);
      wait_jobs(3, "abort_wait");
      repeat (5) @(posedge clk);
      #2 abort = 1'b1;
      @(posedge clk); #2 abort = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_drain_busy: got %b, wanted 1", busy); end
      t = 0;
      while (core_done !== 1'b1 && t < 100) begin @(posedge clk); #2; t++; end
      checks++;
      if (core_done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL abort_drain_done: got done=%b busy=%b, wanted 1 1", core_done, busy); end
      @(posedge clk); #2;
      checks++;
      if (busy !== 1'b0 || fb_we !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b we=%b, wanted 0 0", busy, fb_we); end
      repeat (5) @(posedge clk);
      #2;
      checks++;
      if (q_addr.size() != 2 || fd_cnt != 0) begin errors++; $display("FAIL abort_writes: got %0d writes %0d frame_done, wanted 2 0", q_addr.size(), fd_cnt); end

      clear_log();
      core_lat = 1;
      launch(25'h0100000, 25'h0200000, 25'h0008000);
      wait_jobs(3, "abort_coin");
      t = 0;
      while (core_done !== 1'b1 && t < 100) begin @(posedge clk); #2; t++; end
      abort = 1'b1;
      @(posedge clk); #2 abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || fb_we !== 1'b0 || frame_done !== 1'b0) begin
         errors++; $display("FAIL abort_coin_idle: got busy=%b we=%b fd=%b, wanted 0 0 0", busy, fb_we, frame_done);
      end
      repeat (5) @(posedge clk);
      #2;
      checks++;
      if (q_addr.size() != 2 || fd_cnt != 0) begin errors++; $display("FAIL abort_coin_writes: got %0d writes %0d frame_done, wanted 2 0", q_addr.size(), fd_cnt); end
      test_frame(25'h1C00000, 25'h0100000, 25'h0040000, 3, 1'b0, "abort_next");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_start_ignored();
      test_reset_mid();
      test_wrap();
`ifdef MANDEL_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
